// File: rtl/onehot_rr_arbiter.sv
// rtl/onehot_rr_arbiter.sv - one-hot round-robin arbiter with valid/ready handshake
//
// Purpose: picks one requester per cycle, starting the search at a one-hot
// priority position (internal round-robin pointer, or prio_i when ExtPrio=1)
// and wrapping from NumIn-1 down to 0. The selection is offered downstream on
// valid_o/onehot_o. gnt_o reports the requester whose handshake completed.
//
// Optional feature macro: ONEHOT_RR_ARBITER_LOCK_EN
//   defined   : a stalled selection (valid_o & !ready_i) is locked and held
//               until it is accepted, even if higher-priority requests arrive.
//   undefined : the selection is recomputed every cycle.
//
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   rst_i    - synchronous active-high reset
//   req_i    - per-requester request
//   prio_i   - one-hot priority start (used only when ExtPrio=1)
//   gnt_o    - per-requester acknowledge, set for the handshake cycle only
//   valid_o  - a selection is offered downstream
//   ready_i  - downstream accepts the offered selection
//   onehot_o - one-hot selected requester, zero when valid_o=0

module onehot_rr_arbiter #(
   parameter int NumIn   = 4,
   parameter int ExtPrio = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NumIn-1:0] req_i,
   input  logic [NumIn-1:0] prio_i,
   output logic [NumIn-1:0] gnt_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [NumIn-1:0] onehot_o
);

   generate
      if (NumIn == 1) begin : g_single
         // A single requester needs no pointer and no lock.
         logic unused_single;

         assign onehot_o      = req_i;
         assign valid_o       = req_i[0];
         assign gnt_o         = req_i & {ready_i};
         assign unused_single = ^{clk_i, rst_i, prio_i};
      end else begin : g_multi
         logic [NumIn-1:0] rr_q, rr_d;
         logic [NumIn-1:0] pri;
         logic [NumIn-1:0] hi_mask;
         logic [NumIn-1:0] req_hi;
         logic [NumIn-1:0] req_pick;
         logic [NumIn-1:0] arb_sel;
         logic [NumIn-1:0] sel;
         logic             handshake;

         // Round-robin pick: prefer the lowest request at or above the
         // priority bit; if none, wrap and take the lowest request overall.
         // pri - 1 sets every bit below the priority bit, so its complement
         // masks the "at or above" region.
         always_comb begin
            pri      = (ExtPrio != 0) ? prio_i : rr_q;
            hi_mask  = ~(pri - NumIn'(1));
            req_hi   = req_i & hi_mask;
            req_pick = (|req_hi) ? req_hi : req_i;
            arb_sel  = req_pick & (~req_pick + NumIn'(1));
         end

`ifdef ONEHOT_RR_ARBITER_LOCK_EN
         typedef enum logic {
            ST_IDLE   = 1'b0,
            ST_LOCKED = 1'b1
         } state_e;

         state_e           state_q, state_d;
         logic [NumIn-1:0] lock_q, lock_d;
         logic             lock_hit;

         always_comb begin
            // The lock only applies while its requester is still asking;
            // a dropped request falls back to fresh arbitration this cycle
            // and releases the lock.
            lock_hit = (state_q == ST_LOCKED) && (|(lock_q & req_i));
            sel      = lock_hit ? lock_q : arb_sel;
            state_d  = ST_IDLE;
            lock_d   = '0;
            if ((state_q == ST_LOCKED) && !lock_hit) begin
               state_d = ST_IDLE;
               lock_d  = '0;
            end else if (valid_o && !ready_i) begin
               state_d = ST_LOCKED;
               lock_d  = sel;
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               state_q <= ST_IDLE;
               lock_q  <= '0;
               rr_q    <= NumIn'(1);
            end else begin
               state_q <= state_d;
               lock_q  <= lock_d;
               rr_q    <= rr_d;
            end
         end

`ifndef SYNTHESIS
         a_lock_held: assert property (@(posedge clk_i) disable iff (rst_i)
            (state_q == ST_LOCKED) |-> (|(lock_q & req_i)))
            else $error("locked request dropped before handshake");
`endif
`else
         assign sel = arb_sel;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rr_q <= NumIn'(1);
            end else begin
               rr_q <= rr_d;
            end
         end
`endif

         assign valid_o   = |req_i;
         assign onehot_o  = valid_o ? sel : '0;
         assign handshake = valid_o & ready_i;
         assign gnt_o     = handshake ? onehot_o : '0;

         // After a handshake the pointer moves to the bit after the winner,
         // a rotate-left of the one-hot grant. External priority freezes it.
         always_comb begin
            rr_d = rr_q;
            if (handshake && (ExtPrio == 0)) begin
               rr_d = {onehot_o[NumIn-2:0], onehot_o[NumIn-1]};
            end
         end
      end
   endgenerate

`ifndef SYNTHESIS
   a_onehot0: assert property (@(posedge clk_i) $onehot0(onehot_o))
      else $error("onehot_o has more than one bit set");
   a_gnt_subset: assert property (@(posedge clk_i) ((gnt_o & ~req_i) == '0))
      else $error("gnt_o set for an idle requester");
`endif

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb/tb_onehot_rr_arbiter.sv - self-checking bench for onehot_rr_arbiter

module tb_onehot_rr_arbiter;

`ifdef ONEHOT_RR_ARBITER_LOCK_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   typedef struct {
      logic [3:0] onehot;
      logic [3:0] gnt;
      logic       valid;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] prio = '0;
   logic       rdy = 1'b0;
   logic [3:0] gnt, oh;
   logic       valid;

   logic [3:0] req_e = '0;
   logic [3:0] prio_e = 4'b0001;
   logic       rdy_e = 1'b0;
   logic [3:0] gnt_e, oh_e;
   logic       valid_e;

   logic [0:0] req_s = '0;
   logic [0:0] prio_s = '0;
   logic       rdy_s = 1'b0;
   logic [0:0] gnt_s, oh_s;
   logic       valid_s;

   int n_cmp = 0;
   int n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   onehot_rr_arbiter #(.NumIn(4), .ExtPrio(0)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .prio_i(prio),
      .gnt_o(gnt), .valid_o(valid), .ready_i(rdy), .onehot_o(oh)
   );

   onehot_rr_arbiter #(.NumIn(4), .ExtPrio(1)) dut_ext (
      .clk_i(clk), .rst_i(rst), .req_i(req_e), .prio_i(prio_e),
      .gnt_o(gnt_e), .valid_o(valid_e), .ready_i(rdy_e), .onehot_o(oh_e)
   );

   onehot_rr_arbiter #(.NumIn(1), .ExtPrio(0)) dut_one (
      .clk_i(clk), .rst_i(rst), .req_i(req_s), .prio_i(prio_s),
      .gnt_o(gnt_s), .valid_o(valid_s), .ready_i(rdy_s), .onehot_o(oh_s)
   );

   task automatic apply(input logic r, input logic [3:0] q, input logic k);
      @(negedge clk);
      rst = r;
      req = q;
      rdy = k;
   endtask

   task automatic do_reset();
      apply(1'b1, 4'b0000, 1'b0);
      apply(1'b0, 4'b0000, 1'b0);
   endtask

   task automatic test_reset();
      exp_t e;
      apply(1'b1, 4'b0000, 1'b1);
      sb.push_back('{onehot: 4'b0000, gnt: 4'b0000, valid: 1'b0});
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (valid !== e.valid || oh !== e.onehot || gnt !== e.gnt) begin
         n_err++;
         $display("FAIL reset_idle got v=%b oh=%b g=%b want v=%b oh=%b g=%b",
                  valid, oh, gnt, e.valid, e.onehot, e.gnt);
      end
      // Pointer must start at requester 0.
      apply(1'b0, 4'b1111, 1'b1);
      sb.push_back('{onehot: 4'b0001, gnt: 4'b0001, valid: 1'b1});
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (valid !== e.valid || oh !== e.onehot || gnt !== e.gnt) begin
         n_err++;
         $display("FAIL reset_ptr got v=%b oh=%b g=%b want v=%b oh=%b g=%b",
                  valid, oh, gnt, e.valid, e.onehot, e.gnt);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_oh[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_t e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply(1'b0, 4'b1111, 1'b1);
         sb.push_back('{onehot: exp_oh[i % 4], gnt: exp_oh[i % 4], valid: 1'b1});
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (oh !== e.onehot || gnt !== e.gnt || valid !== e.valid) begin
            n_err++;
            $display("FAIL rotation[%0d] got oh=%b g=%b v=%b want oh=%b g=%b v=%b",
                     i, oh, gnt, valid, e.onehot, e.gnt, e.valid);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] s_req[3] = '{4'b0010, 4'b0011, 4'b0011};
      logic [3:0] s_oh[3]  = '{4'b0010, 4'b0001, 4'b0010};
      exp_t e;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, s_req[i], 1'b1);
         sb.push_back('{onehot: s_oh[i], gnt: s_oh[i], valid: 1'b1});
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (oh !== e.onehot || gnt !== e.gnt) begin
            n_err++;
            $display("FAIL wrap[%0d] got oh=%b g=%b want oh=%b g=%b",
                     i, oh, gnt, e.onehot, e.gnt);
         end
      end
   endtask

   task automatic test_stall();
      logic [3:0] s_req[8] = '{4'b0001, 4'b0100, 4'b0100, 4'b0100,
                               4'b0110, 4'b0110, 4'b0110, 4'b0110};
      logic       s_rdy[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] s_oh[8];
      exp_t e;
      s_oh[0] = 4'b0001;
      s_oh[1] = 4'b0100;
      s_oh[2] = 4'b0100;
      s_oh[3] = 4'b0100;
      s_oh[4] = LockEn ? 4'b0100 : 4'b0010;
      s_oh[5] = LockEn ? 4'b0100 : 4'b0010;
      s_oh[6] = LockEn ? 4'b0100 : 4'b0010;
      s_oh[7] = LockEn ? 4'b0010 : 4'b0100;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply(1'b0, s_req[i], s_rdy[i]);
         sb.push_back('{onehot: s_oh[i], gnt: s_rdy[i] ? s_oh[i] : 4'b0000, valid: 1'b1});
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (oh !== e.onehot || gnt !== e.gnt || valid !== e.valid) begin
            n_err++;
            $display("FAIL stall[%0d] got oh=%b g=%b v=%b want oh=%b g=%b v=%b",
                     i, oh, gnt, valid, e.onehot, e.gnt, e.valid);
         end
      end
   endtask

   task automatic test_reset_mid_lock();
      exp_t e;
      do_reset();
      apply(1'b0, 4'b1000, 1'b0);
      sb.push_back('{onehot: 4'b1000, gnt: 4'b0000, valid: 1'b1});
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (oh !== e.onehot || gnt !== e.gnt) begin
         n_err++;
         $display("FAIL midlock_pre got oh=%b g=%b want oh=%b g=%b", oh, gnt, e.onehot, e.gnt);
      end
      apply(1'b0, 4'b1001, 1'b0);
      sb.push_back('{onehot: LockEn ? 4'b1000 : 4'b0001, gnt: 4'b0000, valid: 1'b1});
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (oh !== e.onehot || gnt !== e.gnt) begin
         n_err++;
         $display("FAIL midlock_held got oh=%b g=%b want oh=%b g=%b", oh, gnt, e.onehot, e.gnt);
      end
      // Handshake offered during reset must not move any state.
      apply(1'b1, 4'b1001, 1'b1);
      apply(1'b0, 4'b1001, 1'b0);
      sb.push_back('{onehot: 4'b0001, gnt: 4'b0000, valid: 1'b1});
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (oh !== e.onehot || gnt !== e.gnt) begin
         n_err++;
         $display("FAIL midlock_post got oh=%b g=%b want oh=%b g=%b", oh, gnt, e.onehot, e.gnt);
      end
   endtask

   task automatic test_ext_prio();
      logic [3:0] s_prio[8] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                4'b0001, 4'b0100, 4'b0010, 4'b1000};
      logic       s_rdy[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] s_oh[8]   = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                4'b0010, 4'b1000, 4'b0010, 4'b1000};
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         req_e  = 4'b1010;
         prio_e = s_prio[i];
         rdy_e  = s_rdy[i];
         sb.push_back('{onehot: s_oh[i], gnt: s_rdy[i] ? s_oh[i] : 4'b0000, valid: 1'b1});
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (oh_e !== e.onehot || gnt_e !== e.gnt || valid_e !== e.valid) begin
            n_err++;
            $display("FAIL ext_prio[%0d] got oh=%b g=%b v=%b want oh=%b g=%b v=%b",
                     i, oh_e, gnt_e, valid_e, e.onehot, e.gnt, e.valid);
         end
      end
      @(negedge clk);
      req_e = '0;
      rdy_e = 1'b0;
   endtask

   task automatic test_single();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_s = 1'(i & 1);
         rdy_s = 1'((i >> 1) & 1);
         sb.push_back('{onehot: {3'b000, req_s[0]}, gnt: {3'b000, req_s[0] & rdy_s},
                        valid: req_s[0]});
         #1;
         e = sb.pop_front();
         n_cmp++;
         if ({3'b000, oh_s} !== e.onehot || {3'b000, gnt_s} !== e.gnt || valid_s !== e.valid) begin
            n_err++;
            $display("FAIL single[%0d] got oh=%b g=%b v=%b want oh=%b g=%b v=%b",
                     i, oh_s, gnt_s, valid_s, e.onehot[0], e.gnt[0], e.valid);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rotation();
      test_wrap();
      test_stall();
      test_reset_mid_lock();
      test_ext_prio();
      test_single();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
